// File: rtl/rvfi_imem_responder_pkg.sv
// Shared constants and helpers for the imem responder.
// Halfword merge used by the symbolic-halfword override.
package rvfi_imem_responder_pkg;

  localparam int AGE_W = 3;

  function automatic logic [31:0] put_half(
    input logic [31:0] w,
    input logic [15:0] h,
    input logic        hi
  );
    put_half = hi ? {h, w[15:0]} : {w[31:16], h};
  endfunction

endpackage

// File: rtl/rvfi_imem_fifo.sv
// In-order response FIFO of {addr, data, age}.
// Age saturates at MIN_LAT and gates head eligibility.
module rvfi_imem_fifo
  import rvfi_imem_responder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MIN_LAT = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_addr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic                     head_ok,
  output logic [XLEN-1:0]          head_addr,
  output logic [31:0]              head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        wr_q         <= wr_q + PW'(1);
        addr_q[wr_q] <= push_addr;
        data_q[wr_q] <= push_data;
      end
      if (pop)
        rd_q <= rd_q + PW'(1);
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + CW'(1);
        pop && !push: cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_q == PW'(i))
          age_q[i] <= '0;
        else if (age_q[i] < AGE_W'(MIN_LAT))
          age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  assign head_ok   = (cnt_q != '0) &&
                     (age_q[rd_q] >= AGE_W'(MIN_LAT));
  assign head_addr = addr_q[rd_q];
  assign head_data = data_q[rd_q];
  assign count     = cnt_q;

endmodule

// File: rtl/rvfi_imem_responder.sv
// Fetch memory model: free data with one symbolic halfword.
// Responses are registered and held until consumed.
module rvfi_imem_responder
  import rvfi_imem_responder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MIN_LAT = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [XLEN-1:0]        imem_addr,
  input  logic [15:0]            imem_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [XLEN-1:0]        req_addr,
  input  logic                   req_stall,
  input  logic [31:0]            rand_rdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [XLEN-1:0]        rsp_addr,
  input  logic                   rsp_stall,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] word_a;
  logic [31:0]     push_data;
  logic            push;
  logic            pop;
  logic            head_ok;
  logic [XLEN-1:0] head_addr;
  logic [31:0]     head_data;

  assign word_a    = req_addr & ~XLEN'(3);
  assign req_ready = (outstanding < CW'(DEPTH)) &&
                     !req_stall && resetn;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Odd imem_addr can never equal an even compare value.
  always_comb begin
    push_data = rand_rdata;
    if (imem_addr == word_a)
      push_data = put_half(push_data, imem_data, 1'b0);
    if (imem_addr == word_a + XLEN'(2))
      push_data = put_half(push_data, imem_data, 1'b1);
  end

  rvfi_imem_fifo #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .MIN_LAT (MIN_LAT)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_addr (word_a),
    .push_data (push_data),
    .pop       (pop),
    .head_ok   (head_ok),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (outstanding)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else if (pop) begin
      rsp_valid <= 1'b0;
    end else if (!rsp_valid && head_ok && !rsp_stall) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= head_data;
      rsp_addr  <= head_addr;
    end
  end

`ifdef RISCV_FORMAL
  a_occ: assert property (@(posedge clock) disable iff (!resetn)
    outstanding <= CW'(DEPTH));
  a_hold: assert property (@(posedge clock) disable iff (!resetn)
    rsp_valid && !rsp_ready |=> rsp_valid &&
      $stable(rsp_rdata) && $stable(rsp_addr));
  a_pop: assert property (@(posedge clock) disable iff (!resetn)
    !(pop && outstanding == '0));
`endif

endmodule

// File: tb/tb_rvfi_imem_responder.sv
// Directed bench for rvfi_imem_responder.
// Default params: XLEN=32, DEPTH=4, MIN_LAT=1.
module tb_rvfi_imem_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_stall;
  logic [31:0] rand_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [31:0] rsp_addr;
  logic        rsp_stall;
  logic [2:0]  outstanding;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rvfi_imem_responder dut (
    .clock       (clock),
    .resetn      (resetn),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_stall   (req_stall),
    .rand_rdata  (rand_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_addr    (rsp_addr),
    .rsp_stall   (rsp_stall),
    .outstanding (outstanding)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] r);
    int k;
    req_valid  = 1'b1;
    req_addr   = a;
    rand_rdata = r;
    #1;
    k = 0;
    while (!req_ready && k < 20) begin
      step();
      k++;
    end
    if (k == 20) chk("req_timeout", 32'(k), 0);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("pop_clr", 32'(rsp_valid), 0);
  endtask

  task automatic txn(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] r,
                     input logic [31:0] ed,
                     input logic [31:0] ea);
    int lat;
    send(a, r);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 2);
    chk({tag, "_data"}, rsp_rdata, ed);
    chk({tag, "_addr"}, rsp_addr, ea);
    pop_one();
  endtask

  initial begin
    logic [31:0] ga [5];
    logic [31:0] gd [5];
    int          n;
    int          seen;
    int          lat;
    logic        acc;

    resetn     = 1'b0;
    imem_addr  = 32'h100;
    imem_data  = 16'hBEEF;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_stall  = 1'b0;
    rand_rdata = 32'h1234_5678;
    rsp_ready  = 1'b0;
    rsp_stall  = 1'b0;
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_outst", 32'(outstanding), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_raddr", rsp_addr, 0);
    step();
    resetn = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 1);
    req_stall = 1'b1;
    #1;
    chk("stall_ready", 32'(req_ready), 0);
    req_stall = 1'b0;

    txn("lo", 32'h100, 32'h1234_5678,
        32'h1234_BEEF, 32'h100);
    imem_addr = 32'h102;
    txn("hi", 32'h103, 32'h1234_5678,
        32'hBEEF_5678, 32'h100);
    imem_addr = 32'h101;
    txn("odd", 32'h100, 32'h1234_5678,
        32'h1234_5678, 32'h100);
    imem_addr = 32'hFFFF_FFFE;
    txn("top", 32'hFFFF_FFFC, 32'h1234_5678,
        32'hBEEF_5678, 32'hFFFF_FFFC);
    txn("wrap", 32'h0, 32'h1234_5678,
        32'h1234_5678, 32'h0);

    // fill to DEPTH with responses blocked
    imem_addr = 32'h1;
    for (int i = 0; i < 4; i++) begin
      req_valid  = 1'b1;
      req_addr   = 32'(i * 4);
      rand_rdata = 32'hA000_0000 | 32'(i * 4);
      #1;
      chk("fill_ready", 32'(req_ready), 1);
      step();
    end
    req_addr   = 32'h10;
    rand_rdata = 32'hA000_0010;
    #1;
    chk("full_ready", 32'(req_ready), 0);
    chk("full_outst", 32'(outstanding), 4);
    step();
    chk("full_ready2", 32'(req_ready), 0);
    chk("full_outst2", 32'(outstanding), 4);
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (rsp_valid) begin
        ga[n] = rsp_addr;
        gd[n] = rsp_rdata;
        n++;
      end
      acc = req_valid && req_ready;
      step();
      if (acc) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    chk("drain_n", 32'(n), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        chk("ord_addr", ga[i], 32'(i * 4));
        chk("ord_data", gd[i],
            32'hA000_0000 | 32'(i * 4));
      end
    end
    chk("drain_outst", 32'(outstanding), 0);

    // response held while not consumed
    send(32'h20, 32'h1111_2222);
    wait_rsp(lat);
    chk("hold_lat", 32'(lat), 2);
    for (int i = 0; i < 3; i++) begin
      rand_rdata = ~rand_rdata;
      rsp_stall  = ~rsp_stall;
      step();
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_rdata, 32'h1111_2222);
      chk("hold_addr", rsp_addr, 32'h20);
    end
    rsp_stall = 1'b0;
    pop_one();

    // rsp_stall blocks raising valid
    rsp_stall = 1'b1;
    send(32'h24, 32'h3333_4444);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(rsp_valid), 0);
    end
    rsp_stall = 1'b0;
    step();
    chk("unstall_valid", 32'(rsp_valid), 1);
    chk("unstall_data", rsp_rdata, 32'h3333_4444);
    pop_one();

    // async reset mid-stream
    send(32'h40, 32'h5555_6666);
    send(32'h44, 32'h7777_8888);
    step();
    chk("pre_rst_outst", 32'(outstanding), 2);
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_outst", 32'(outstanding), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    step();
    resetn    = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("stale_rsp", 32'(seen), 0);
    txn("post_rst", 32'h48, 32'h9999_AAAA,
        32'h9999_AAAA, 32'h48);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
